// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch stage of the single-cycle MIPS core. Holds the PC, fetches
//            each instruction over a req/ack handshake, presents it to
//            decode/control, and commits the next PC once per instruction.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            imem_req/addr       - fetch request and address (addr == pc)
//            imem_ack/rdata      - fetch completion and instruction word
//            instr/instr_valid   - captured instruction, valid during EXEC
//            pc/pc_plus4         - current PC and its jal link value
//            jump/branch/nequal/jr/alu_zero/rs_data - next-PC controls
//            stall               - hold the instruction in EXEC
//            retired             - retired-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        nequal,
    input  logic        jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic [31:0] retired
);

    localparam logic [1:0] c_BOOT  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic        w_jr_q;
    logic        w_taken;
    logic [31:0] w_next_pc;
    logic        w_unused_ok;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Control derives jr from funct alone, so only trust it on R-type opcodes.
    assign w_jr_q  = jr & (r_instr[31:26] == 6'b000000);
    assign w_taken = branch & (alu_zero ^ nequal);
    assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // The jr target is word-aligned by force; the low bits of rs are dropped.
    assign w_unused_ok = &{1'b0, rs_data[1:0]};

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_jr_q) begin
            w_next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_taken) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_BOOT;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
        end else begin
            case (r_state)
                c_BOOT: begin
                    r_state <= c_FETCH;
                end
                c_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (!stall) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_BOOT;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == c_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == c_EXEC);
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Directed self-checking bench for fetch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] c_RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        nequal = 1'b0;
    logic        jr = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] retired;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc  = c_RST_PC;
    logic [31:0] exp_ret = 32'd0;
    logic [31:0] held;

    fetch_pc_unit #(.RESET_PC(c_RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .jump       (jump),
        .branch     (branch),
        .nequal     (nequal),
        .jr         (jr),
        .alu_zero   (alu_zero),
        .rs_data    (rs_data),
        .stall      (stall),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one fetch at exp_pc after 'waits' idle cycles; ends in EXEC.
    task automatic fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("req_wait", {31'd0, imem_req}, 32'd1);
            chk("addr_wait", imem_addr, exp_pc);
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, exp_pc);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("instr", instr, word);
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("req_exec", {31'd0, imem_req}, 32'd0);
    endtask

    // One unstalled EXEC cycle with the given controls; ends in FETCH.
    task automatic exec(input logic j, input logic br, input logic ne, input logic jrr,
                        input logic z, input logic [31:0] rs, input logic [31:0] exp_next);
        jump = j; branch = br; nequal = ne; jr = jrr; alu_zero = z; rs_data = rs;
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        @(negedge clk);
        jump = 1'b0; branch = 1'b0; nequal = 1'b0; jr = 1'b0; alu_zero = 1'b0; rs_data = 32'd0;
        exp_ret = exp_ret + 32'd1;
        exp_pc  = exp_next;
        chk("next_pc", pc, exp_next);
        chk("retired", retired, exp_ret);
        chk("valid_off", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, c_RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Three sequential instructions, zero-wait acks
        fetch(32'h0000_0020, 0); exec(0, 0, 0, 0, 0, 0, 32'h0000_0104);
        fetch(32'h0000_0020, 0); exec(0, 0, 0, 0, 0, 0, 32'h0000_0108);
        fetch(32'h0000_0020, 0); exec(0, 0, 0, 0, 0, 0, 32'h0000_010C);
        chk("retired3", retired, 32'd3);

        // jr with misaligned rs, then jr ignored on addi opcode
        fetch(32'h03E0_0008, 0); exec(0, 0, 0, 1, 0, 32'h0000_0403, 32'h0000_0400);
        fetch(32'h2000_0008, 0); exec(0, 0, 0, 1, 0, 32'h0000_0403, 32'h0000_0404);
        fetch(32'h03E0_0008, 0); exec(0, 0, 0, 1, 0, 32'h0000_0200, 32'h0000_0200);

        // beq taken, bne taken, beq not taken (offset -1)
        fetch(32'h1000_FFFF, 0); exec(0, 1, 0, 0, 1, 0, 32'h0000_0200);
        fetch(32'h1400_FFFF, 0); exec(0, 1, 1, 0, 0, 0, 32'h0000_0200);
        fetch(32'h1000_FFFF, 0); exec(0, 1, 0, 0, 0, 0, 32'h0000_0204);

        // j from 0x1000_0000, back, then jal with branch also asserted
        fetch(32'h03E0_0008, 0); exec(0, 0, 0, 1, 0, 32'h1000_0000, 32'h1000_0000);
        fetch(32'h0800_0040, 0); exec(1, 0, 0, 0, 0, 0, 32'h1000_0100);
        fetch(32'h03E0_0008, 0); exec(0, 0, 0, 1, 0, 32'h1000_0000, 32'h1000_0000);
        fetch(32'h0C00_0040, 0);
        chk("jal_link", pc_plus4, 32'h1000_0004);
        exec(1, 1, 0, 0, 1, 0, 32'h1000_0100);

        // Delayed ack (3 waits), then two stalled EXEC cycles with a stray ack
        fetch(32'h0000_0020, 3);
        stall = 1'b1;
        held  = retired;
        for (int i = 0; i < 2; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hA5A5_A5A5;
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'h1000_0100);
            chk("stall_instr", instr, 32'h0000_0020);
            chk("stall_retired", retired, held);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        exec(0, 0, 0, 0, 0, 0, 32'h1000_0104);

        // Wrap from 0xFFFF_FFFC
        fetch(32'h03E0_0008, 0); exec(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        fetch(32'h0000_0020, 0);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        exec(0, 0, 0, 0, 0, 0, 32'h0000_0000);

        // Reset in mid-FETCH, stale ack arrives during and after reset
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_pc", pc, c_RST_PC);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("post_rst_instr", instr, 32'd0);
        chk("post_rst_retired", retired, 32'd0);
        chk("post_rst_addr", imem_addr, c_RST_PC);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
